// File: rtl/ins_fetch_ctrl.sv
// ins_fetch_ctrl: instruction fetch FSM with a single 4-word line buffer.
// Define IFETCH_LINE_REUSE_EN to serve redirects that land in the buffered line without refetching.
module ins_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         iSIG_PCSrc,
  input  logic [31:0]  iaddr4branch,
  input  logic         istall,
  output logic         omem_req,
  output logic [31:0]  omem_addr,
  input  logic         imem_ack,
  input  logic [127:0] imem_in,
  output logic [31:0]  oins,
  output logic         oins_valid,
  output logic [31:0]  opc
);
  typedef enum logic [1:0] {IDLE, FILL, DRAIN, SERVE} state_t;
  state_t       r_state, w_state_nxt;
  logic [31:0]  r_pc, r_addr, w_pc_nxt;
  logic [127:0] r_line;
  logic         w_fill_done, w_consume, w_reuse;
  assign w_fill_done = (r_state == FILL) && imem_ack && !iSIG_PCSrc;
  assign w_consume   = (r_state == SERVE) && !istall && !iSIG_PCSrc;
  assign w_pc_nxt    = iSIG_PCSrc ? (iaddr4branch & 32'hFFFF_FFFC) : w_consume ? r_pc + 32'd4 : r_pc;
`ifdef IFETCH_LINE_REUSE_EN
  logic [27:0] r_tag;
  logic        r_line_valid;
  assign w_reuse = r_line_valid && (iaddr4branch[31:4] == r_tag);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_tag        <= '0;
      r_line_valid <= 1'b0;
    end else if (w_fill_done) begin
      r_tag        <= r_pc[31:4];
      r_line_valid <= 1'b1;
    end
`else
  assign w_reuse = 1'b0;
`endif
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  w_state_nxt = FILL;
      FILL:  w_state_nxt = iSIG_PCSrc ? (imem_ack ? FILL : DRAIN) : (imem_ack ? SERVE : FILL);
      DRAIN: w_state_nxt = imem_ack ? FILL : DRAIN;
      SERVE: w_state_nxt = iSIG_PCSrc ? (w_reuse ? SERVE : FILL)
                                      : ((w_consume && r_pc[3:2] == 2'd3) ? FILL : SERVE);
    endcase
  end
  // DRAIN keeps the address of the request still in flight; otherwise it follows the next pc
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_addr  <= {RESET_PC[31:4], 4'b0};
      r_line  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_addr  <= (w_state_nxt == DRAIN) ? r_addr : {w_pc_nxt[31:4], 4'b0};
      if (w_fill_done) r_line <= imem_in;
    end
  assign omem_req   = (r_state == FILL) || (r_state == DRAIN);
  assign omem_addr  = r_addr;
  assign oins       = r_line[{r_pc[3:2], 5'd0} +: 32];
  assign oins_valid = (r_state == SERVE);
  assign opc        = r_pc;
endmodule
